// File: rtl/mdu_iter_pkg.sv
// Shared defines for the iterative RV64M multiply/divide unit: op codes,
// widths, FSM states and the operand-conditioning helpers.
package mdu_iter_pkg;

    localparam int XLEN     = 64;
    localparam int OP_W     = 4;
    localparam int MduWidth = 32;

    localparam logic [OP_W-1:0] MduMul    = 4'd0;
    localparam logic [OP_W-1:0] MduMulh   = 4'd1;
    localparam logic [OP_W-1:0] MduMulhsu = 4'd2;
    localparam logic [OP_W-1:0] MduMulhu  = 4'd3;
    localparam logic [OP_W-1:0] MduDiv    = 4'd4;
    localparam logic [OP_W-1:0] MduDivu   = 4'd5;
    localparam logic [OP_W-1:0] MduRem    = 4'd6;
    localparam logic [OP_W-1:0] MduRemu   = 4'd7;
    localparam logic [OP_W-1:0] MduMulw   = 4'd8;
    localparam logic [OP_W-1:0] MduDivw   = 4'd9;
    localparam logic [OP_W-1:0] MduDivuw  = 4'd10;
    localparam logic [OP_W-1:0] MduRemw   = 4'd11;
    localparam logic [OP_W-1:0] MduRemuw  = 4'd12;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} mdu_state_e;

    typedef struct packed {
        logic valid;   // listed op code
        logic is_w;    // 32-bit word form
        logic is_div;  // divide or remainder
        logic is_rem;  // remainder result
        logic hi;      // high half of product
        logic sa;      // operator_1 treated as signed
        logic sb;      // operator_2 treated as signed
    } mdu_info_t;

    function automatic mdu_info_t op_info(input logic [OP_W-1:0] op);
        mdu_info_t i;
        i = '0;
        i.valid = 1'b1;
        case (op)
            MduMul:    begin i.sa = 1'b1; i.sb = 1'b1; end
            MduMulh:   begin i.hi = 1'b1; i.sa = 1'b1; i.sb = 1'b1; end
            MduMulhsu: begin i.hi = 1'b1; i.sa = 1'b1; end
            MduMulhu:  i.hi = 1'b1;
            MduDiv:    begin i.is_div = 1'b1; i.sa = 1'b1; i.sb = 1'b1; end
            MduDivu:   i.is_div = 1'b1;
            MduRem:    begin i.is_div = 1'b1; i.is_rem = 1'b1; i.sa = 1'b1; i.sb = 1'b1; end
            MduRemu:   begin i.is_div = 1'b1; i.is_rem = 1'b1; end
            MduMulw:   begin i.is_w = 1'b1; i.sa = 1'b1; i.sb = 1'b1; end
            MduDivw:   begin i.is_w = 1'b1; i.is_div = 1'b1; i.sa = 1'b1; i.sb = 1'b1; end
            MduDivuw:  begin i.is_w = 1'b1; i.is_div = 1'b1; end
            MduRemw:   begin i.is_w = 1'b1; i.is_div = 1'b1; i.is_rem = 1'b1; i.sa = 1'b1; i.sb = 1'b1; end
            MduRemuw:  begin i.is_w = 1'b1; i.is_div = 1'b1; i.is_rem = 1'b1; end
            default:   i.valid = 1'b0;
        endcase
        return i;
    endfunction

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
        return {{(XLEN-MduWidth){x[MduWidth-1]}}, x[MduWidth-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] x, input logic is_w,
                                               input logic sgn);
        if (!is_w) return x;
        return sgn ? sext_w(x) : {{(XLEN-MduWidth){1'b0}}, x[MduWidth-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step
    import mdu_iter_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: 1 bit per cycle shift-add multiply
// and restoring divide on magnitudes, with sign fix-up on the final cycle.
module mdu_iter
    import mdu_iter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] mdu_op,
    input  logic [XLEN-1:0] operator_1,
    input  logic [XLEN-1:0] operator_2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] mdu_result
);

    mdu_state_e        state, state_nxt;
    logic [OP_W-1:0]   op_q;
    logic [XLEN-1:0]   ax_q, bx_q, ma_q, mb_q, rem_q, quo_q, result_q;
    logic [2*XLEN-1:0] prod_q;
    logic [6:0]        cnt_q;

    mdu_info_t       in_i, cur;
    logic [XLEN-1:0] ax, bx, ma, mb;

    assign in_i = op_info(mdu_op);
    assign ax   = ext_op(operator_1, in_i.is_w, in_i.sa);
    assign bx   = ext_op(operator_2, in_i.is_w, in_i.sb);
    assign ma   = mag(ax, in_i.sa);
    assign mb   = mag(bx, in_i.sb);
    assign cur  = op_info(op_q);

    // Special cases complete with zero iterations; the result is built on the final cycle.
    logic            div0, ovf, spec;
    logic [XLEN-1:0] min_neg;
    logic [6:0]      limit;

    assign min_neg = cur.is_w ? {{(XLEN-MduWidth+1){1'b1}}, {(MduWidth-1){1'b0}}}
                              : {1'b1, {(XLEN-1){1'b0}}};
    assign div0  = cur.is_div && (bx_q == '0);
    assign ovf   = cur.is_div && cur.sa && (ax_q == min_neg) && (bx_q == '1);
    assign spec  = !cur.valid || div0 || ovf;
    assign limit = spec ? 7'd0 : (cur.is_w ? 7'd32 : 7'd64);

    logic busy, last, acc;
    assign busy = (state == StMul) || (state == StDiv);
    assign last = busy && (cnt_q == limit);
    assign acc  = in_ready && in_valid && !flush;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_nxt;
    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, ma_q} : '0);
    assign prod_nxt = {mul_sum, prod_q[XLEN-1:1]};

    logic [XLEN-1:0] rem_nxt;
    logic            q_bit;

    mdu_div_step #(.W(XLEN)) u_div_step (
        .rem_in  (rem_q),
        .bit_in  (quo_q[XLEN-1]),
        .divisor (mb_q),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // Word multiplies stop after 32 shifts, leaving the product 32 bits up.
    logic              neg_a, neg_b;
    logic [2*XLEN-1:0] prod_w, prod_s;
    logic [XLEN-1:0]   mul_res, q_s, r_s, spec_res, pre_res, fin_res;

    assign neg_a    = cur.sa && ax_q[XLEN-1];
    assign neg_b    = cur.sb && bx_q[XLEN-1];
    assign prod_w   = cur.is_w ? (prod_q >> MduWidth) : prod_q;
    assign prod_s   = (neg_a ^ neg_b) ? -prod_w : prod_w;
    assign mul_res  = cur.hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    assign q_s      = (neg_a ^ neg_b) ? -quo_q : quo_q;
    assign r_s      = neg_a ? -rem_q : rem_q;
    assign spec_res = !cur.valid ? '0 :
                      div0       ? (cur.is_rem ? ax_q : '1) :
                                   (cur.is_rem ? '0 : ax_q);
    assign pre_res  = spec ? spec_res : (cur.is_div ? (cur.is_rem ? r_s : q_s) : mul_res);
    assign fin_res  = cur.is_w ? sext_w(pre_res) : pre_res;

    always_ff @(posedge clk) begin
        if (rst) state <= StIdle;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            StIdle:       if (in_valid) state_nxt = in_i.is_div ? StDiv : StMul;
            StMul, StDiv: if (cnt_q == limit) state_nxt = StDone;
            StDone:       if (out_ready) state_nxt = StIdle;
            default:      state_nxt = StIdle;
        endcase
        if (flush) state_nxt = StIdle;
    end

    assign in_ready   = (state == StIdle);
    assign out_valid  = (state == StDone);
    assign mdu_result = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            ax_q     <= '0;
            bx_q     <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (acc) begin
            op_q   <= mdu_op;
            ax_q   <= ax;
            bx_q   <= bx;
            ma_q   <= ma;
            mb_q   <= mb;
            rem_q  <= '0;
            // Word divides start with the dividend MSB aligned to the top.
            quo_q  <= in_i.is_w ? (ma << MduWidth) : ma;
            prod_q <= {{XLEN{1'b0}}, mb};
            cnt_q  <= '0;
        end else if (busy && !flush) begin
            if (last) begin
                result_q <= fin_res;
            end else begin
                cnt_q <= cnt_q + 7'd1;
                if (state == StMul) begin
                    prod_q <= prod_nxt;
                end else begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[XLEN-2:0], q_bit};
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter: results, latency, backpressure,
// flush and mid-operation reset.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [OP_W-1:0] mdu_op;
    logic [XLEN-1:0] operator_1, operator_2, mdu_result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mdu_op     (mdu_op),
        .operator_1 (operator_1),
        .operator_2 (operator_2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mdu_result (mdu_result)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge with the unit idle; returns #1 after the accept edge.
    task automatic start(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
        in_valid   = 1'b1;
        mdu_op     = op;
        operator_1 = a;
        operator_2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n, output logic busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run(input string tag, input logic [OP_W-1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input int lat, input logic [XLEN-1:0] exp);
        int   n;
        logic ok;
        start(op, a, b);
        wait_done(n, ok);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, mdu_result, exp);
        chk({tag, "_busy"}, 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    typedef struct {
        string           tag;
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] a, b;
        int              lat;
        logic [XLEN-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int   n;
        logic ok, seen;

        vecs.push_back('{"mul",     MduMul,    64'd7, 64'hFFFFFFFFFFFFFFFD, 65, 64'hFFFFFFFFFFFFFFEB});
        vecs.push_back('{"mulhu",   MduMulhu,  '1, '1, 65, 64'hFFFFFFFFFFFFFFFE});
        vecs.push_back('{"mulh",    MduMulh,   '1, '1, 65, 64'h0});
        vecs.push_back('{"mulw",    MduMulw,   64'h7FFFFFFF, 64'd2, 33, 64'hFFFFFFFFFFFFFFFE});
        vecs.push_back('{"div",     MduDiv,    64'hFFFFFFFFFFFFFFF9, 64'd2, 65, 64'hFFFFFFFFFFFFFFFD});
        vecs.push_back('{"rem",     MduRem,    64'hFFFFFFFFFFFFFFF9, 64'd2, 65, 64'hFFFFFFFFFFFFFFFF});
        vecs.push_back('{"divu",    MduDivu,   64'd100, 64'd7, 65, 64'd14});
        vecs.push_back('{"remu",    MduRemu,   64'd100, 64'd7, 65, 64'd2});
        vecs.push_back('{"divw",    MduDivw,   64'hFFFFFFF9, 64'd2, 33, 64'hFFFFFFFFFFFFFFFD});
        vecs.push_back('{"divu_z",  MduDivu,   64'd5, 64'd0, 1, 64'hFFFFFFFFFFFFFFFF});
        vecs.push_back('{"rem_z",   MduRem,    64'd5, 64'd0, 1, 64'd5});
        vecs.push_back('{"div_ovf", MduDiv,    64'h8000000000000000, '1, 1, 64'h8000000000000000});
        vecs.push_back('{"rem_ovf", MduRem,    64'h8000000000000000, '1, 1, 64'h0});
        vecs.push_back('{"divw_ovf", MduDivw,  64'h80000000, '1, 1, 64'hFFFFFFFF80000000});
        vecs.push_back('{"remuw_z", MduRemuw,  64'h80000000, 64'd0, 1, 64'hFFFFFFFF80000000});
        vecs.push_back('{"bad_op",  4'hF,      64'd9, 64'd3, 1, 64'h0});

        rst        = 1'b1;
        in_valid   = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        mdu_op     = '0;
        operator_1 = '0;
        operator_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_result", mdu_result, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) run(vecs[i].tag, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].exp);

        // Backpressure: result held in DONE while writeback stalls.
        out_ready = 1'b0;
        start(MduDivu, 64'd100, 64'd7);
        wait_done(n, ok);
        chk("bp_lat", 64'(n), 64'd65);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {61'd0, out_valid, in_ready, 1'b0}, 64'd4);
            chk("bp_res", mdu_result, 64'd14);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {62'd0, out_valid, in_ready}, 64'd1);

        // Flush partway through a divide.
        start(MduDiv, 64'd1000, 64'd3);
        repeat (20) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_idle", {62'd0, out_valid, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_novalid", 64'(seen), 64'd0);
        run("mul_after_flush", MduMul, 64'd3, 64'd4, 65, 64'd12);

        // Reset in the middle of a multiply.
        start(MduMul, 64'd5, 64'd5);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", mdu_result, 64'd0);
        run("remu_after_rst", MduRemu, 64'd100, 64'd7, 65, 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV64M multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Consumes the same decoded operand pair (operator_1, operator_2) from the decode stage.
- Produces a 64-bit result into the same writeback mux as the ALU result.
- Multi-cycle: valid/ready handshake on both sides, so decode stalls while the unit is busy.

Parameters:
- XLEN, 64, operand/result width (matches ImmWidth).
- OP_W, 4, width of mdu_op.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request
- mdu_op  input  OP_W  operation code (shared defines)
- operator_1  input  XLEN  rs1 value
- operator_2  input  XLEN  rs2 value
- flush  input  1  abort any in-flight operation
- out_valid  output  1  result available
- out_ready  input  1  writeback accepts result
- mdu_result  output  XLEN  final result

Behaviour:
- Ops:
  - MUL, MULH, MULHSU, MULHU.
  - DIV, DIVU, REM, REMU.
  - MULW, DIVW, DIVUW, REMW, REMUW.
  - Unlisted codes complete as a special case with result 0.
- Reset (rst sampled high on a clk edge): state=IDLE, in_ready=1, out_valid=0, mdu_result=0, all iteration registers cleared. Applies mid-operation.
- States: IDLE, MUL, DIV, DONE.
- Accept: in_valid && in_ready in IDLE. Operands and op are latched. in_ready=0 in every state except IDLE.
- Transitions from IDLE after accept:
  - Special case → DONE next cycle.
  - Otherwise → MUL or DIV.
- MUL: shift-add, 1 bit/cycle, on absolute values; sign fixed at the end.
  - 64 iterations (32 for MULW).
  - Product register is 2*XLEN.
  - MUL/MULW take the low half (MULW sign-extends bit 31); MULH* take the high half.
- DIV: restoring, 1 quotient bit/cycle, on magnitudes.
  - 64 iterations (32 for W ops).
  - Quotient sign = sign1 ^ sign2; remainder sign = dividend sign.
  - W ops use the sign- or zero-extended low 32 bits; results are sign-extended from bit 31.
- Latency: accept at edge 0 → out_valid high after edge N+1, where N is the iteration count. Special cases → out_valid after edge 1.
- Special cases (no iteration):
  - Divisor = 0: DIV/DIVU/DIVW/DIVUW → all ones; REM*/REM*W → dividend (W forms sign-extended from bit 31).
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend, remainder = 0. XLEN and W widths are detected separately.
- DONE:
  - out_valid=1; mdu_result is stable while out_ready=0.
  - out_valid && out_ready → IDLE next cycle, out_valid=0.
  - No new accept in the same cycle.
- flush (any state except during rst): → IDLE next cycle, out_valid=0, result discarded. Priority: rst > flush > normal operation.
- in_valid while busy is ignored. Decode holds the request until in_ready.

Decomposition:
- Shared defines file gets:
  - MduOp codes (OP_W wide): MduMul, MduMulh, MduMulhsu, MduMulhu, MduDiv, MduDivu, MduRem, MduRemu, MduMulw, MduDivw, MduDivuw, MduRemw, MduRemuw.
  - MduWidth.
  - State encodings.
- One sub-module: mdu_div_step, the combinational single restoring-division step (partial remainder, divisor → next remainder, quotient bit).
- Multiply datapath and FSM stay in mdu_iter.

Test Plan:
- MUL 7 × 0xFFFFFFFFFFFFFFFD → 0xFFFFFFFFFFFFFFEB; out_valid exactly 65 cycles after accept; in_ready=0 throughout.
- MULHU 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. MULH same operands → 0. MULW 0x7FFFFFFF × 2 → 0xFFFFFFFFFFFFFFFE after 33 cycles.
- DIV -7/2 → 0xFFFFFFFFFFFFFFFD; REM -7/2 → 0xFFFFFFFFFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with out_valid after 1 cycle:
  - DIVU 5/0 → 0xFFFFFFFFFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x8000000000000000/-1 → 0x8000000000000000.
  - REM same operands → 0.
  - DIVW 0x80000000/-1 → 0xFFFFFFFF80000000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result and out_valid stable, in_ready=0. Then out_ready=1 → IDLE next cycle, in_ready=1.
- Flush at iteration 20 of a DIV → IDLE next cycle, no out_valid. A following MUL 3×4 → 12.
- rst asserted mid-MUL → all outputs at reset values next cycle.
